// File: rtl/reg_file_reader.sv
//==============================================================================
// Module  : reg_file_reader
// Brief   : Register file with a registered, stallable read port (1-cycle latency)
// Revision: 1.0
//==============================================================================
`default_nettype none

module reg_file_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_gnt,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  output logic [7:0]       rd_count
);

  localparam logic [7:0] c_CNT_ONE = 8'd1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q,  rd_data_d;
  logic [7:0]       rd_count_q, rd_count_d;

  logic             w_gnt;
  logic             w_fire;
  logic             w_bypass;
  logic [WIDTH-1:0] w_rd_src;

  // Storage array: one register per entry, cleared asynchronously.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else if (we && (waddr == AW'(gi))) begin
        mem_q[gi] <= wdata;
      end
    end
  end

  // A slot is free when empty or being drained this cycle.
  assign w_gnt    = rd_req & (~rd_valid_q | rd_ready);
  assign w_fire   = rd_valid_q & rd_ready;
  assign w_bypass = we & (waddr == rd_addr);
  assign w_rd_src = w_bypass ? wdata : mem_q[rd_addr];

  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_count_d = rd_count_q;
    if (w_gnt) begin
      rd_valid_d = 1'b1;
      rd_data_d  = w_rd_src;
    end else if (w_fire) begin
      rd_valid_d = 1'b0;
    end
    if (w_fire) begin
      rd_count_d = rd_count_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_count_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_gnt   = w_gnt;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_count = rd_count_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_reader.sv
//==============================================================================
// Module  : tb_reg_file_reader
// Brief   : Directed self-checking bench for reg_file_reader
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_reg_file_reader;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       rd_req;
  logic [2:0] rd_addr;
  logic       rd_gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [7:0] rd_count;

  int n_chk = 0;
  int n_err = 0;

  reg_file_reader #(.WIDTH(8), .DEPTH(8), .AW(3)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .rd_count (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    rd_req = 1'b0; rd_addr = '0; rd_ready = 1'b0;
    #3;
    chk("rst_valid", rd_valid, 0);
    chk("rst_data",  rd_data,  0);
    chk("rst_count", rd_count, 0);
    rd_req = 1'b1;
    #1;
    chk("rst_gnt", rd_gnt, 1);
    rd_req = 1'b0;
    tick();
    rst_n = 1'b1;

    // Read every address after reset
    rd_ready = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_req = 1'b1; rd_addr = 3'(a);
      tick();
      chk("zero_valid", rd_valid, 1);
      chk("zero_data",  rd_data,  0);
    end
    rd_req = 1'b0;
    tick();
    chk("zero_drain_valid", rd_valid, 0);
    chk("zero_count", rd_count, 8);

    // Write then read
    we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
    tick();
    we = 1'b0; rd_req = 1'b1; rd_addr = 3'd3;
    tick();
    rd_req = 1'b0;
    chk("wr_rd_valid", rd_valid, 1);
    chk("wr_rd_data",  rd_data,  8'hA5);
    chk("wr_rd_count_pre", rd_count, 8);
    tick();
    chk("wr_rd_count", rd_count, 9);
    chk("drain_valid", rd_valid, 0);
    chk("drain_data_keep", rd_data, 8'hA5);

    // Same-edge write bypass
    we = 1'b1; waddr = 3'd5; wdata = 8'h3C; rd_req = 1'b1; rd_addr = 3'd5;
    tick();
    we = 1'b0; rd_req = 1'b0;
    chk("bypass_data", rd_data, 8'h3C);
    tick();
    chk("bypass_count", rd_count, 10);

    // Stall with write to the source register
    we = 1'b1; waddr = 3'd2; wdata = 8'h11;
    tick();
    we = 1'b0; rd_req = 1'b1; rd_addr = 3'd2; rd_ready = 1'b0;
    tick();
    chk("stall_first_data", rd_data, 8'h11);
    rd_addr = 3'd4;
    #1;
    chk("stall_gnt_low", rd_gnt, 0);
    we = 1'b1; waddr = 3'd2; wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      we = 1'b0;
      chk("stall_data",  rd_data,  8'h11);
      chk("stall_valid", rd_valid, 1);
      chk("stall_count", rd_count, 10);
      chk("stall_gnt",   rd_gnt,   0);
    end
    rd_ready = 1'b1; rd_addr = 3'd2;
    #1;
    chk("unstall_gnt", rd_gnt, 1);
    tick();
    chk("unstall_count", rd_count, 11);
    chk("unstall_data",  rd_data,  8'h22);
    chk("unstall_valid", rd_valid, 1);
    rd_req = 1'b0;
    tick();
    chk("unstall_drain_count", rd_count, 12);
    chk("unstall_drain_valid", rd_valid, 0);

    // Back-to-back streaming and counter wrap
    for (int a = 0; a < 8; a++) begin
      we = 1'b1; waddr = 3'(a); wdata = 8'(a + 1);
      tick();
    end
    we = 1'b0; rd_ready = 1'b1; rd_req = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      tick();
      chk("stream_valid", rd_valid, 1);
      chk("stream_data",  rd_data,  32'(a + 1));
    end
    chk("stream_count", rd_count, 19);
    for (int i = 0; i < 236; i++) begin
      rd_addr = 3'(i);
      tick();
    end
    chk("wrap_valid_held", rd_valid, 1);
    chk("wrap_data", rd_data, 8'h04);
    chk("wrap_count_255", rd_count, 255);
    rd_req = 1'b0;
    tick();
    chk("wrap_count_0", rd_count, 0);

    // Asynchronous reset mid-transfer
    we = 1'b1; waddr = 3'd6; wdata = 8'h77;
    tick();
    we = 1'b0; rd_req = 1'b1; rd_addr = 3'd6;
    tick();
    tick();
    chk("prereset_count", rd_count, 1);
    chk("prereset_data",  rd_data,  8'h77);
    rd_req = 1'b0; rd_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", rd_valid, 0);
    chk("async_data",  rd_data,  0);
    chk("async_count", rd_count, 0);
    #1;
    rst_n = 1'b1;
    rd_ready = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_req = 1'b1; rd_addr = 3'(a);
      tick();
      chk("post_rst_data", rd_data, 0);
    end
    rd_req = 1'b0;
    tick();
    chk("post_rst_count", rd_count, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
